// File: rtl/instruction_line_fill_if.sv
// Refill engine bundle: cache miss request, word-wide memory read port and line fill output.
interface instruction_line_fill_if #(
   parameter int unsigned ADDR_W = 16
);
   logic              miss_req;
   logic [ADDR_W-1:0] miss_addr;
   logic              busy;
   logic              mem_rd;
   logic [ADDR_W-1:0] mem_addr;
   logic [15:0]       mem_rdata;
   logic              mem_ack;
   logic              fill_valid;
   logic [ADDR_W-1:0] fill_addr;
   logic [63:0]       dataLine;

   modport master (
      output miss_req, miss_addr, mem_rdata, mem_ack,
      input  busy, mem_rd, mem_addr, fill_valid, fill_addr, dataLine
   );

   modport slave (
      input  miss_req, miss_addr, mem_rdata, mem_ack,
      output busy, mem_rd, mem_addr, fill_valid, fill_addr, dataLine
   );
endinterface

// File: rtl/instruction_line_fill.sv
// Instruction cache line refill: fetches four 16-bit words and strobes the assembled 64-bit line.
// Define CRITICAL_WORD_FIRST_EN to start the fetch at the missing word and wrap modulo 4.
module instruction_line_fill #(
   parameter int unsigned ADDR_W = 16
) (
   input logic                    clk,
   input logic                    rst_n,
   instruction_line_fill_if.slave bus
);

   typedef enum logic [1:0] {StIdle, StFetch, StDone} state_e;

   state_e            state_q;
   logic [1:0]        cnt_q;
   logic [2:0]        nwords_q;
   logic [ADDR_W-1:0] fill_addr_q;
   logic [63:0]       line_q;
   logic              fill_valid_q;
   logic [1:0]        start_word;
   logic              unused_addr;

`ifdef CRITICAL_WORD_FIRST_EN
   assign start_word  = bus.miss_addr[2:1];
   assign unused_addr = bus.miss_addr[0];
`else
   assign start_word  = 2'd0;
   assign unused_addr = ^bus.miss_addr[2:0];
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= StIdle;
         cnt_q        <= 2'd0;
         nwords_q     <= 3'd0;
         fill_addr_q  <= '0;
         line_q       <= 64'h0;
         fill_valid_q <= 1'b0;
      end else begin
         fill_valid_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (bus.miss_req) begin
                  fill_addr_q <= {bus.miss_addr[ADDR_W-1:3], 3'b000};
                  cnt_q       <= start_word;
                  nwords_q    <= 3'd0;
                  state_q     <= StFetch;
               end
            end
            StFetch: begin
               if (bus.mem_ack) begin
                  // Slot is chosen by word index, so the layout is by address in either order.
                  line_q[{~cnt_q, 4'b0000} +: 16] <= bus.mem_rdata;
                  cnt_q    <= cnt_q + 2'd1;
                  nwords_q <= nwords_q + 3'd1;
                  if (nwords_q == 3'd3) begin
                     state_q      <= StDone;
                     fill_valid_q <= 1'b1;
                  end
               end
            end
            StDone: begin
               state_q <= StIdle;
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

   assign bus.busy       = (state_q != StIdle);
   assign bus.mem_rd     = (state_q == StFetch);
   assign bus.mem_addr   = {fill_addr_q[ADDR_W-1:3], cnt_q, 1'b0};
   assign bus.fill_valid = fill_valid_q;
   assign bus.fill_addr  = fill_addr_q;
   assign bus.dataLine   = line_q;

endmodule

// File: doc/instruction_line_fill.md
# instruction_line_fill

Refill engine between the instruction cache and main instruction memory. On a cache miss it fetches the four 16-bit words of the missing 8-byte line over a word-wide request/acknowledge memory port. It assembles them into a 64-bit line and presents the line to the cache with a one-cycle fill strobe. With a zero-wait memory, a miss is serviced in 5 cycles, which matches the cache's miss-wait window.

## Interface
- ADDR_W, 16, byte address width; a line is 8 bytes (4 words).
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- miss_req  in  1  level; cache reports a miss on miss_addr.
- miss_addr  in  ADDR_W  byte address of the missing instruction.
- busy  out  1  refill in progress (FETCH or DONE).
- mem_rd  out  1  memory read request, held until mem_ack.
- mem_addr  out  ADDR_W  word byte-address being read; bit 0 is always 0.
- mem_rdata  in  16  read data, valid when mem_ack=1.
- mem_ack  in  1  one-cycle acknowledge; may arrive in the same cycle as mem_rd.
- fill_valid  out  1  one-cycle strobe; dataLine and fill_addr are valid.
- fill_addr  out  ADDR_W  line base address, {miss_addr[ADDR_W-1:3], 3'b000}.
- dataLine  out  64  assembled line; word at base+0 is in [63:48], base+2 in [47:32], base+4 in [31:16], base+6 in [15:0].

## Operation
- FSM states: IDLE, FETCH, DONE.
- IDLE:
  - If miss_req=1, latch fill_addr, set the word counter to the start word, and go to FETCH.
  - mem_ack is ignored in IDLE.
- FETCH:
  - mem_rd=1 and mem_addr=fill_addr+{cnt,1'b0}, where cnt is a 2-bit word index.
  - On mem_ack, write mem_rdata into the dataLine slot selected by cnt.
  - If this is the 4th word, go to DONE; otherwise cnt=cnt+1, wrapping 3→0.
  - With no ack, hold mem_rd, mem_addr and cnt unchanged.
- DONE:
  - fill_valid=1 for exactly one cycle, then return to IDLE.
  - miss_req is not sampled in DONE. A still-asserted miss_req starts a new refill from IDLE on the next cycle; the cache deasserts it once the line is installed.
- miss_req falling during FETCH does not abort the refill. The line is still delivered.
- miss_addr changing after it is latched has no effect until the next IDLE acceptance.
- A words-fetched counter (0..4), separate from cnt, decides when the line is complete. This makes completion independent of the start word.
- Reset values:
  - state=IDLE.
  - busy, mem_rd, fill_valid = 0.
  - mem_addr, fill_addr = 0.
  - dataLine = 64'h0.
  - counters = 0.
- Reset asserted mid-refill abandons the transaction immediately. No fill_valid is produced, and a partially written dataLine is cleared.

## Timing
- All outputs are registered, except mem_rd, mem_addr and busy, which decode the current state and registers.
- Edge E0 samples miss_req=1.
- With zero-wait memory (mem_ack in the same cycle as mem_rd), words are accepted at edges E1..E4 and fill_valid=1 during the cycle after E4. That is 5 cycles from the request edge to the strobe.
- Each memory wait cycle adds one cycle to the total.
- dataLine is stable from fill_valid until the next refill's first accepted word.
- Back-to-back misses cost a minimum of 6 cycles per line, including the IDLE cycle.

## Configuration
- CRITICAL_WORD_FIRST_EN defined:
  - The start word is miss_addr[2:1], and the fetch order wraps modulo 4.
  - Example: start 2 reads base+4, +6, +0, +2.
- CRITICAL_WORD_FIRST_EN undefined:
  - The start word is always 0; the order is base+0, +2, +4, +6.
- The final dataLine layout, latency and fill_valid timing are identical in both builds. Only the mem_addr sequence differs.

## Test plan
- Zero-wait fill: miss_addr=16'h0123 with memory returning words 16'hA000..A003 for base 16'h0120. Required:
  - fill_addr=16'h0120.
  - dataLine=64'hA000_A001_A002_A003.
  - fill_valid exactly one cycle, 5 cycles after the request edge.
- Wait states: memory delays each ack by 2 cycles. Required:
  - mem_rd and mem_addr held steady while waiting.
  - fill_valid at cycle 13.
  - Same dataLine as the zero-wait fill.
- Fetch order: miss_addr=16'h0046.
  - Macro defined: mem_addr sequence 0x0046, 0x0040, 0x0042, 0x0044.
  - Macro undefined: 0x0040, 0x0042, 0x0044, 0x0046.
  - In both builds, dataLine is laid out by address.
- Reset mid-fill: assert rst_n=0 after 2 acks. Required:
  - All outputs return to reset values asynchronously.
  - No fill_valid.
  - After release, a new miss fills correctly.
- Noise and early drop:
  - mem_ack pulses while IDLE are ignored; dataLine stays 0.
  - miss_req dropped after the first ack still yields one fill_valid with the complete line.
- Back-to-back: miss_req held through two different lines (0x0100, then 0x0200 applied in the cycle after fill_valid). Required: two fill_valid strobes separated by 6 cycles, each with correct fill_addr and dataLine.
